mdu_hilo_ctrl: RTL and testbench

- Multi-cycle controller and HI/LO register file for MULT/MULTU/DIV/DIVU/MTHI/MTLO, directly downstream of the combinational multiply/divide unit.
- Latches operands and op, holds them stable on the unit's inputs for a programmable number of cycles, then captures the 64-bit {HI,LO} result.
- Drives a stall request to the pipeline while an operation is in flight; supplies HI/LO to MFHI/MFLO in the execute stage.

---
 rtl/mdu_hilo_ctrl.sv | 119 +++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_ctrl.sv
// HI/LO register file and multi-cycle sequencer for the external combinational mul/div unit.
// Holds operands stable for a fixed latency, then captures {HI,LO} from md_c.
module mdu_hilo_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [1:0]  md_op,
  input  logic [63:0] md_c,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] MulCnt = 6'(MUL_LAT - 1);
  localparam logic [5:0] DivCnt = 6'(DIV_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        divzero_q, divzero_d;
  logic        done_q, done_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic [1:0]  md_op_q, md_op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    md_a_d    = md_a_q;
    md_b_d    = md_b_q;
    md_op_d   = md_op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (!flush) begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
          if (start) begin
            md_a_d    = rs_val;
            md_b_d    = rt_val;
            md_op_d   = op;
            cnt_d     = op[1] ? DivCnt : MulCnt;
            divzero_d = op[1] & (rt_val == 32'd0);
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          // Divide-by-zero still completes and pulses done, but leaves HI/LO alone.
          if (!divzero_q) begin
            hi_d = md_c[63:32];
            lo_d = md_c[31:0];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
      md_a_q    <= 32'd0;
      md_b_q    <= 32'd0;
      md_op_q   <= 2'b00;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
      md_a_q    <= md_a_d;
      md_b_q    <= md_b_d;
      md_op_q   <= md_op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == StBusy);
  assign stall = busy | (start & ~flush);
  assign done  = done_q;
  assign md_a  = md_a_q;
  assign md_b  = md_b_q;
  assign md_op = md_op_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl with a behavioural model of the combinational mul/div unit.
module tb_mdu_hilo_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_op;
  logic [63:0] md_c;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  mdu_hilo_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .flush (flush),
    .md_a  (md_a),
    .md_b  (md_b),
    .md_op (md_op),
    .md_c  (md_c),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational mul/div unit; divide by zero yields all ones.
  always_comb begin
    case (md_op)
      2'b00: md_c = {32'd0, md_a} * {32'd0, md_b};
      2'b01: md_c = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
      2'b10: md_c = (md_b == 32'd0) ? '1 : {md_a % md_b, md_a / md_b};
      default: md_c = (md_b == 32'd0) ? '1 :
                      {32'($signed(md_a) % $signed(md_b)), 32'($signed(md_a) / $signed(md_b))};
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, run it to completion, optionally disturb with mthi+start at busy cycle 'disturb'.
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int disturb);
    int   n;
    logic stable;
    logic quiet;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1;
    check({tag, ".stall_at_start"}, 64'(stall), 64'd1);
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rs_val = '0; rt_val = '0;
    n = 0; stable = 1'b1; quiet = 1'b1;
    while (busy && n < 200) begin
      if (md_a !== a || md_b !== b || md_op !== o || stall !== 1'b1) stable = 1'b0;
      if (done !== 1'b0) quiet = 1'b0;
      if (n == disturb) begin
        mthi = 1'b1; start = 1'b1; op = 2'b00; rs_val = 32'hDEADBEEF; rt_val = 32'd1;
      end else begin
        mthi = 1'b0; start = 1'b0; rs_val = '0; rt_val = '0;
      end
      n++;
      tick();
    end
    mthi = 1'b0; start = 1'b0;
    check({tag, ".busy_cycles"}, 64'(n), 64'(lat));
    check({tag, ".held_operands"}, 64'(stable), 64'd1);
    check({tag, ".no_early_done"}, 64'(quiet), 64'd1);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic ok;
    int   n;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    tick();
    tick();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hilo", {hi, lo}, 64'd0);
    check("reset.md_ab", {md_a, md_b}, 64'd0);
    check("reset.md_op", 64'(md_op), 64'd0);
    rst = 1'b0;
    tick();

    // MULT -2 * 3
    issue("mult", 2'b01, 32'hFFFFFFFE, 32'd3, 4, 32'hFFFFFFFF, 32'hFFFFFFFA, -1);
    // DIVU 100 / 7
    issue("divu", 2'b10, 32'd100, 32'd7, 32, 32'd2, 32'd14, -1);

    // MTHI / MTLO then divide by zero leaves them intact
    rs_val = 32'h12345678; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    check("mthi.hi", 64'(hi), 64'h12345678);
    check("mthi.lo_kept", 64'(lo), 64'd14);
    rs_val = 32'h9ABCDEF0; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    check("mtlo.lo", 64'(lo), 64'h9ABCDEF0);
    issue("div0", 2'b11, 32'd5, 32'd0, 32, 32'h12345678, 32'h9ABCDEF0, -1);

    // start and mthi under flush in IDLE are ignored
    start = 1'b1; mthi = 1'b1; flush = 1'b1; rs_val = 32'h55555555;
    #1;
    check("idle_flush.stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; mthi = 1'b0; flush = 1'b0;
    check("idle_flush.busy", 64'(busy), 64'd0);
    check("idle_flush.hi", 64'(hi), 64'h12345678);

    // MULTU flushed on busy cycle 2
    op = 2'b00; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) ok = 1'b0;
      tick();
    end
    check("flush.no_write_no_done", 64'(ok), 64'd1);
    issue("multu_after_flush", 2'b00, 32'd2, 32'd3, 4, 32'd0, 32'd6, -1);

    // DIVU with mthi+start driven mid-busy: both ignored
    issue("divu_disturb", 2'b10, 32'd1000, 32'd3, 32, 32'd1, 32'd333, 10);

    // start + mtlo together in IDLE
    op = 2'b00; rs_val = 32'd1; rt_val = 32'd20; start = 1'b1; mtlo = 1'b1;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_start.lo_now", 64'(lo), 64'd1);
    check("mtlo_start.busy", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("mtlo_start.busy_cycles", 64'(n), 64'd4);
    check("mtlo_start.result", {hi, lo}, 64'd20);

    // Reset in the middle of a MULT
    op = 2'b01; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.hilo", {hi, lo}, 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
      tick();
    end
    check("midrst.no_late_write", 64'(ok), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
